// File: rtl/scandoubler_if.sv
// Video bundle between the core video mux (master) and the line doubler (slave).
// en_vid is a one-cycle strobe per source pixel with no backpressure. The outputs change only on internal ce_x2 strobes.
interface scandoubler_if #(
  parameter int IW = 4,
  parameter int OW = 3
);
  logic          en_vid;
  logic          hs_in;
  logic          vs_in;
  logic [IW-1:0] r_in;
  logic [IW-1:0] g_in;
  logic [IW-1:0] b_in;
  logic [1:0]    sl_mode;
  logic          hs_out;
  logic          vs_out;
  logic [OW-1:0] r_out;
  logic [OW-1:0] g_out;
  logic [OW-1:0] b_out;

  modport master (
    output en_vid, hs_in, vs_in, r_in, g_in, b_in, sl_mode,
    input  hs_out, vs_out, r_out, g_out, b_out
  );

  modport slave (
    input  en_vid, hs_in, vs_in, r_in, g_in, b_in, sl_mode,
    output hs_out, vs_out, r_out, g_out, b_out
  );
endinterface

// File: rtl/scandoubler_ex.sv
// 15 kHz -> 31 kHz line doubler: buffers one input line in a ping-pong RAM and
// replays it twice at 2x pixel rate, with optional scanline darkening.
module scandoubler_ex #(
  parameter int IW = 4,
  parameter int OW = 3,
  parameter int AW = 10,
  parameter int CW = 8
) (
  input  logic          clk_sys,
  input  logic          reset,
  scandoubler_if.slave  vid
);

  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [AW-1:0] HCNT_MAX = '1;

  logic          en_d, ce_x1, ce_x2;
  logic [CW-1:0] cnt, pixsz;
  logic          hs_d, vs_d, bank;
  logic [AW-1:0] hcnt, hs_max, hs_rise, sd_hcnt;
  logic          hs_sd;
  logic [3*OW-1:0] sd_out, wr_data;
  logic          hs_o, vs_o, sl_phase;
  logic [OW-1:0] r_o, g_o, b_o;
  logic          hs_fall, hs_rise_ev, vs_chg;

  logic [3*OW-1:0] ram [0:(2**(AW+1))-1];

  assign hs_fall    = hs_d & ~vid.hs_in;
  assign hs_rise_ev = ~hs_d & vid.hs_in;
  assign vs_chg     = vs_d ^ vid.vs_in;
  assign wr_data    = {vid.r_in[IW-1 -: OW], vid.g_in[IW-1 -: OW], vid.b_in[IW-1 -: OW]};

  function automatic logic [OW-1:0] shade(input logic [OW-1:0] x, input logic [1:0] mode,
                                          input logic odd);
    logic [OW-1:0] y;
    y = x;
    if (odd) begin
      case (mode)
        2'd1:    y = x - (x >> 2);
        2'd2:    y = x >> 1;
        2'd3:    y = x >> 2;
        default: y = x;
      endcase
    end
    return y;
  endfunction

  // Pixel-rate strobes: ce_x2 adds a mid-pixel pulse at half the measured period.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      en_d  <= 1'b0;
      ce_x1 <= 1'b0;
      ce_x2 <= 1'b0;
      cnt   <= '0;
      pixsz <= '0;
    end else begin
      en_d  <= vid.en_vid;
      ce_x1 <= 1'b0;
      ce_x2 <= 1'b0;
      if (vid.en_vid && !en_d) begin
        ce_x1 <= 1'b1;
        ce_x2 <= 1'b1;
        cnt   <= '0;
        pixsz <= cnt >> 1;
      end else begin
        if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
        if (cnt == pixsz) ce_x2 <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      hs_d    <= 1'b0;
      vs_d    <= 1'b1;
      bank    <= 1'b0;
      hcnt    <= '0;
      hs_max  <= '0;
      hs_rise <= '0;
    end else if (ce_x1) begin
      hs_d <= vid.hs_in;
      vs_d <= vid.vs_in;
      if (hs_fall) begin
        hs_max <= hcnt;
        hcnt   <= '0;
        bank   <= ~bank;
      end else if (hcnt != HCNT_MAX) begin
        hcnt <= hcnt + 1'b1;
      end
      if (hs_rise_ev) hs_rise <= hcnt;
      // A new field always starts writing into bank 0.
      if (vs_chg) bank <= 1'b0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (ce_x1) ram[{bank, hcnt}] <= wr_data;
  end

  // Replay side: later assignments take priority within the same strobe.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      sd_hcnt <= '0;
      hs_sd   <= 1'b1;
      sd_out  <= '0;
    end else if (ce_x2) begin
      sd_hcnt <= sd_hcnt + 1'b1;
      if (hs_fall) sd_hcnt <= hs_max;
      if (sd_hcnt == hs_max) begin
        sd_hcnt <= '0;
        hs_sd   <= 1'b0;
      end
      if (sd_hcnt == hs_rise) hs_sd <= 1'b1;
      sd_out <= ram[{~bank, sd_hcnt}];
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      hs_o     <= 1'b1;
      vs_o     <= 1'b1;
      sl_phase <= 1'b0;
      r_o      <= '0;
      g_o      <= '0;
      b_o      <= '0;
    end else if (ce_x2) begin
      hs_o <= hs_sd;
      r_o  <= shade(sd_out[3*OW-1 -: OW], vid.sl_mode, sl_phase);
      g_o  <= shade(sd_out[2*OW-1 -: OW], vid.sl_mode, sl_phase);
      b_o  <= shade(sd_out[OW-1:0],       vid.sl_mode, sl_phase);
      if (hs_o && !hs_sd) begin
        vs_o <= vs_d;
        // Scanline parity restarts with each field.
        if (vs_d != vs_o) sl_phase <= 1'b0;
        else              sl_phase <= ~sl_phase;
      end
    end
  end

  assign vid.hs_out = hs_o;
  assign vid.vs_out = vs_o;
  assign vid.r_out  = r_o;
  assign vid.g_out  = g_o;
  assign vid.b_out  = b_o;

endmodule

// File: tb/tb_scandoubler_ex.sv
// Directed bench for scandoubler_ex: 256-pixel lines, en_vid every 4 clocks,
// outputs sampled on the falling clock edge.
`timescale 1ns/1ps
module tb_scandoubler_ex;
  localparam int IW = 4;
  localparam int OW = 3;
  localparam int AW = 10;
  localparam int CW = 8;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  int   checks  = 0;
  int   errors  = 0;

  logic       gen_on   = 1'b0;
  logic       gen_ramp = 1'b1;
  logic [3:0] c_r = 4'h0, c_g = 4'h0, c_b = 4'h0;
  int         line_len = 256;
  int         hs_low   = 16;
  int         line_cnt = 0;
  int         cur_len;
  logic [31:0] pv;

  scandoubler_if #(.IW(IW), .OW(OW)) vid();

  scandoubler_ex #(.IW(IW), .OW(OW), .AW(AW), .CW(CW)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .vid     (vid)
  );

  always #5 clk_sys = ~clk_sys;

  // Pixel source: one en_vid pulse every 4 clocks, hs low for the first hs_low pixels.
  initial begin
    vid.en_vid  = 1'b0;
    vid.hs_in   = 1'b1;
    vid.vs_in   = 1'b1;
    vid.r_in    = '0;
    vid.g_in    = '0;
    vid.b_in    = '0;
    vid.sl_mode = 2'd0;
    forever begin
      cur_len = line_len;
      line_cnt++;
      for (int p = 0; p < cur_len; p++) begin
        @(posedge clk_sys); #1;
        if (gen_on) begin
          vid.en_vid = 1'b1;
          vid.hs_in  = (p >= hs_low);
          pv = p;
          if (gen_ramp) begin
            vid.r_in = pv[3:0];
            vid.g_in = 4'h0;
            vid.b_in = 4'h0;
          end else begin
            vid.r_in = c_r;
            vid.g_in = c_g;
            vid.b_in = c_b;
          end
        end
        @(posedge clk_sys); #1;
        vid.en_vid = 1'b0;
        repeat (2) @(posedge clk_sys);
      end
    end
  end

  task automatic wait_line();
    int start;
    int n;
    start = line_cnt;
    n = 0;
    while (line_cnt == start && n < 6000) begin
      @(posedge clk_sys);
      n++;
    end
    if (line_cnt == start) begin
      checks++;
      errors++;
      $display("FAIL line_start_timeout: got no new line, required one within 6000 clk");
    end
  endtask

  task automatic wait_hs_fall();
    logic prev;
    bit   found;
    @(negedge clk_sys);
    prev  = vid.hs_out;
    found = 0;
    for (int n = 0; n < 2000 && !found; n++) begin
      @(negedge clk_sys);
      if (prev === 1'b1 && vid.hs_out === 1'b0) found = 1;
      prev = vid.hs_out;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL hs_fall_timeout: got no hs_out falling edge, required one within 2000 clk");
    end
  endtask

  task automatic sync_line();
    wait_line();
    wait_hs_fall();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk_sys);
    checks++;
    if ({vid.hs_out, vid.vs_out} !== 2'b11) begin
      errors++;
      $display("FAIL reset_sync: got hs/vs %b, required 11", {vid.hs_out, vid.vs_out});
    end
    reset = 1'b0;
    repeat (3) @(negedge clk_sys);
    checks++;
    if ({vid.r_out, vid.g_out, vid.b_out} !== 9'd0) begin
      errors++;
      $display("FAIL reset_rgb: got %h, required 000", {vid.r_out, vid.g_out, vid.b_out});
    end
    checks++;
    if (dut.hs_max !== '0) begin
      errors++;
      $display("FAIL reset_hs_max: got %0d, required 0", dut.hs_max);
    end
    gen_on = 1'b1;
  endtask

  task automatic test_timing();
    int n;
    repeat (3) wait_line();
    sync_line();
    n = 0;
    do begin
      @(negedge clk_sys);
      n++;
    end while (vid.hs_out !== 1'b1 && n < 1000);
    checks++;
    if (n != 32) begin
      errors++;
      $display("FAIL hs_low_width: got %0d clk, required 32", n);
    end
    do begin
      @(negedge clk_sys);
      n++;
    end while (vid.hs_out !== 1'b0 && n < 2000);
    checks++;
    if (n != 512) begin
      errors++;
      $display("FAIL hs_period: got %0d clk, required 512", n);
    end
  endtask

  // Ramp pixel p lands at address p-1, so m strobes after hs_out falls r_out = m[3:1].
  task automatic test_ramp();
    int ms[5] = '{1, 5, 38, 127, 200};
    int elapsed;
    logic [7:0] mv;
    sync_line();
    elapsed = 0;
    for (int i = 0; i < 5; i++) begin
      repeat (2 * ms[i] - elapsed) @(negedge clk_sys);
      elapsed = 2 * ms[i];
      mv = ms[i][7:0];
      checks++;
      if (vid.r_out !== mv[3:1]) begin
        errors++;
        $display("FAIL ramp_m%0d: got r_out %0d, required %0d", ms[i], vid.r_out, mv[3:1]);
      end
    end
    checks++;
    if ({vid.g_out, vid.b_out} !== 6'd0) begin
      errors++;
      $display("FAIL ramp_gb: got %h, required 00", {vid.g_out, vid.b_out});
    end
    wait_hs_fall();
    repeat (132) @(negedge clk_sys);
    checks++;
    if (vid.r_out !== 3'd1) begin
      errors++;
      $display("FAIL ramp_second_pass: got r_out %0d, required 1", vid.r_out);
    end
  endtask

  task automatic test_vsync_scanline();
    logic prev_hs, prev_vs;
    bit   found;
    logic [8:0] exp_rgb [6];
    logic [1:0] next_mode [6];
    gen_ramp    = 1'b0;
    c_r         = 4'hE;
    c_g         = 4'h8;
    c_b         = 4'hF;
    vid.sl_mode = 2'd2;
    repeat (3) wait_line();
    wait_line();
    repeat (240) @(posedge clk_sys);
    #1 vid.vs_in = 1'b0;
    prev_hs = vid.hs_out;
    prev_vs = vid.vs_out;
    found   = 0;
    for (int n = 0; n < 1500 && !found; n++) begin
      @(negedge clk_sys);
      if (prev_hs === 1'b1 && vid.hs_out === 1'b0) found = 1;
      else begin
        prev_hs = vid.hs_out;
        prev_vs = vid.vs_out;
      end
    end
    checks++;
    if (!found || prev_vs !== 1'b1) begin
      errors++;
      $display("FAIL vs_before_edge: got vs_out %b (edge seen %0d), required 1", prev_vs, found);
    end
    checks++;
    if (vid.vs_out !== 1'b0) begin
      errors++;
      $display("FAIL vs_at_edge: got vs_out %b, required 0", vid.vs_out);
    end
    // Lines after the field change alternate phase 0 / phase 1.
    exp_rgb   = '{{3'd7,3'd4,3'd7}, {3'd3,3'd2,3'd3}, {3'd7,3'd4,3'd7},
                  {3'd1,3'd1,3'd1}, {3'd7,3'd4,3'd7}, {3'd6,3'd3,3'd6}};
    next_mode = '{2'd2, 2'd3, 2'd3, 2'd1, 2'd1, 2'd0};
    for (int l = 0; l < 6; l++) begin
      if (l > 0) wait_hs_fall();
      repeat (200) @(negedge clk_sys);
      checks++;
      if ({vid.r_out, vid.g_out, vid.b_out} !== exp_rgb[l]) begin
        errors++;
        $display("FAIL scanline_line%0d: got %h, required %h", l,
                 {vid.r_out, vid.g_out, vid.b_out}, exp_rgb[l]);
      end
      vid.sl_mode = next_mode[l];
    end
    wait_hs_fall();
    wait_hs_fall();
    repeat (200) @(negedge clk_sys);
    checks++;
    if ({vid.r_out, vid.g_out, vid.b_out} !== {3'd7, 3'd4, 3'd7}) begin
      errors++;
      $display("FAIL scanline_off_odd: got %h, required 1e7", {vid.r_out, vid.g_out, vid.b_out});
    end
    vid.vs_in = 1'b1;
    gen_ramp  = 1'b1;
  endtask

  task automatic test_saturation();
    wait_line();
    line_len = (1 << AW) + 20;
    wait_line();
    line_len = 256;
    wait_line();
    checks++;
    if (dut.hcnt !== 10'h3FF) begin
      errors++;
      $display("FAIL sat_hcnt: got %0d, required 1023", dut.hcnt);
    end
    repeat (8) @(posedge clk_sys);
    checks++;
    if (dut.hs_max !== 10'h3FF) begin
      errors++;
      $display("FAIL sat_hs_max: got %0d, required 1023", dut.hs_max);
    end
    repeat (2) wait_line();
    sync_line();
    repeat (76) @(negedge clk_sys);
    checks++;
    if (vid.r_out !== 3'd3) begin
      errors++;
      $display("FAIL sat_recover_m38: got r_out %0d, required 3", vid.r_out);
    end
    repeat (178) @(negedge clk_sys);
    checks++;
    if (vid.r_out !== 3'd7) begin
      errors++;
      $display("FAIL sat_recover_m127: got r_out %0d, required 7", vid.r_out);
    end
  endtask

  task automatic test_hold();
    logic [10:0] snap;
    gen_on = 1'b0;
    repeat (20) @(posedge clk_sys);
    @(negedge clk_sys);
    snap = {vid.hs_out, vid.vs_out, vid.r_out, vid.g_out, vid.b_out};
    repeat (300) @(negedge clk_sys);
    checks++;
    if ({vid.hs_out, vid.vs_out, vid.r_out, vid.g_out, vid.b_out} !== snap) begin
      errors++;
      $display("FAIL hold_no_en: got %h, required %h",
               {vid.hs_out, vid.vs_out, vid.r_out, vid.g_out, vid.b_out}, snap);
    end
    gen_on = 1'b1;
  endtask

  task automatic test_reset_midframe();
    repeat (2) wait_line();
    sync_line();
    repeat (10) @(negedge clk_sys);
    checks++;
    if (vid.r_out !== 3'd2 || vid.hs_out !== 1'b0) begin
      errors++;
      $display("FAIL pre_reset: got hs %b r %0d, required hs 0 r 2", vid.hs_out, vid.r_out);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({vid.hs_out, vid.vs_out} !== 2'b11) begin
      errors++;
      $display("FAIL midreset_sync: got hs/vs %b, required 11", {vid.hs_out, vid.vs_out});
    end
    checks++;
    if ({vid.r_out, vid.g_out, vid.b_out} !== 9'd0) begin
      errors++;
      $display("FAIL midreset_rgb: got %h, required 000", {vid.r_out, vid.g_out, vid.b_out});
    end
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    repeat (2) wait_line();
    sync_line();
    repeat (40) @(negedge clk_sys);
    checks++;
    if (vid.r_out !== 3'd2) begin
      errors++;
      $display("FAIL recover_m20: got r_out %0d, required 2", vid.r_out);
    end
    repeat (114) @(negedge clk_sys);
    checks++;
    if (vid.r_out !== 3'd6) begin
      errors++;
      $display("FAIL recover_m77: got r_out %0d, required 6", vid.r_out);
    end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_ramp();
    test_vsync_scanline();
    test_saturation();
    test_hold();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
